// File: rtl/aes256_key_expand_if.sv
// Round-key stream interface for the AES-256 key expander.
// The master side supplies the key and start and consumes round keys.
interface aes256_key_expand_if;
  logic         start;
  logic [255:0] key;
  logic         rk_ready;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         busy;
  logic         done;

  modport master (
    output start, key, rk_ready,
    input  rk_valid, rk_idx, rk, busy, done
  );

  modport slave (
    input  start, key, rk_ready,
    output rk_valid, rk_idx, rk, busy, done
  );
endinterface

// File: rtl/aes256_key_expand.sv
// Iterative AES-256 key schedule: one 32-bit schedule word per cycle,
// 15 round keys emitted in order on a valid/ready stream.
module aes256_key_expand (
  input  logic               clk,
  input  logic               rst,
  aes256_key_expand_if.slave kx
);

  localparam int unsigned NK = 8;
  localparam int unsigned NR = 14;

  localparam logic [2047:0] SBOX_TBL = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OUT  = 2'd1,
    GEN  = 2'd2
  } state_t;

  // Entry b sits at bit offset (255-b)*8, i.e. {~b, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    sub_word = {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [2:0] idx);
    case (idx)
      3'd0:    rcon = 8'h01;
      3'd1:    rcon = 8'h02;
      3'd2:    rcon = 8'h04;
      3'd3:    rcon = 8'h08;
      3'd4:    rcon = 8'h10;
      3'd5:    rcon = 8'h20;
      3'd6:    rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t            state, state_next;
  logic [7:0][31:0]  win, win_next;
  logic [5:0]        i, i_next;
  logic [127:0]      rk_q, rk_next;
  logic [3:0]        idx_q, idx_next;
  logic              valid_q, valid_next;
  logic              busy_q, busy_next;
  logic              done_q, done_next;

  logic [31:0]       t_rot, t_sub, t_mix, w_new;
  logic [2:0]        rcon_idx;

  // Next schedule word from the sliding window.
  always_comb begin
    rcon_idx = 3'(i[5:3] - 3'd1);
    t_rot    = (i[2:0] == 3'd0) ? {win[7][23:0], win[7][31:24]} : win[7];
    t_sub    = sub_word(t_rot);
    case (i[2:0])
      3'd0:    t_mix = t_sub ^ {rcon(rcon_idx), 24'h000000};
      3'd4:    t_mix = t_sub;
      default: t_mix = win[7];
    endcase
    w_new = win[0] ^ t_mix;
  end

  always_comb begin
    state_next = state;
    win_next   = win;
    i_next     = i;
    rk_next    = rk_q;
    idx_next   = idx_q;
    valid_next = valid_q;
    done_next  = 1'b0;

    case (state)
      IDLE: begin
        // The done cycle is still the tail of the previous run; start is ignored there.
        if (kx.start && !done_q) begin
          for (int k = 0; k < 8; k++) begin
            win_next[k] = kx.key[32*(7-k) +: 32];
          end
          i_next     = 6'(NK);
          rk_next    = kx.key[255:128];
          idx_next   = 4'd0;
          valid_next = 1'b1;
          state_next = OUT;
        end
      end

      OUT: begin
        if (kx.rk_ready) begin
          if (idx_q == 4'd0) begin
            rk_next  = {win[4], win[5], win[6], win[7]};
            idx_next = 4'd1;
          end else if (idx_q == 4'(NR)) begin
            valid_next = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            valid_next = 1'b0;
            state_next = GEN;
          end
        end
      end

      GEN: begin
        for (int k = 0; k < 7; k++) begin
          win_next[k] = win[k+1];
        end
        win_next[7] = w_new;
        i_next      = i + 6'd1;
        if (i[1:0] == 2'd3) begin
          rk_next    = {win[5], win[6], win[7], w_new};
          idx_next   = idx_q + 4'd1;
          valid_next = 1'b1;
          state_next = OUT;
        end
      end

      default: begin
        valid_next = 1'b0;
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      win     <= '0;
      i       <= '0;
      rk_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      win     <= win_next;
      i       <= i_next;
      rk_q    <= rk_next;
      idx_q   <= idx_next;
      valid_q <= valid_next;
      busy_q  <= busy_next;
      done_q  <= done_next;
    end
  end

  assign kx.rk_valid = valid_q;
  assign kx.rk_idx   = idx_q;
  assign kx.rk       = rk_q;
  assign kx.busy     = busy_q;
  assign kx.done     = done_q;

endmodule

// File: tb/tb_aes256_key_expand.sv
// Bench for aes256_key_expand: GF(2^8)-derived reference schedule, scoreboard on
// accepted round keys, vector table plus reset/restart/back-to-back sequences.
module tb_aes256_key_expand;

  logic clk = 1'b0;
  logic rst = 1'b1;
  aes256_key_expand_if kx();

  aes256_key_expand dut (
    .clk(clk),
    .rst(rst),
    .kx (kx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] rk;
  } exp_t;

  typedef struct {
    logic [255:0] key;
    int           pct;
    logic [127:0] rk0;
    bit           full;
  } vec_t;

  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_C3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           ready_pct = 100;
  exp_t         sb_q[$];
  logic [7:0]   sb[256];
  logic [127:0] got[16];
  int           got_cyc[16];
  int           done_cnt = 0;
  int           done_cyc = 0;
  logic         hold = 1'b0;
  logic         rst_prev = 1'b1;
  logic [127:0] hold_rk;
  logic [3:0]   hold_idx;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    kx.rk_ready = (ready_pct >= 100) ? 1'b1 : 1'($urandom_range(0, 99) < ready_pct);
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a;
      b = b >> 1;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  // S-box from multiplicative inverse plus affine map, independent of any table.
  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  task automatic push_model(input logic [255:0] k);
    logic [31:0] w[60];
    logic [31:0] t;
    logic [7:0]  rc;
    exp_t        e;
    for (int n = 0; n < 8; n++) w[n] = k[32*(7-n) +: 32];
    rc = 8'h01;
    for (int n = 8; n < 60; n++) begin
      t = w[n-1];
      if (n % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (n % 8 == 4) begin
        t = subw(t);
      end
      w[n] = w[n-8] ^ t;
    end
    for (int r = 0; r < 15; r++) begin
      e.idx = 4'(r);
      e.rk  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      sb_q.push_back(e);
    end
  endtask

  // Output monitor: scoreboard pop on handshake, hold stability, done/busy.
  always @(negedge clk) begin
    exp_t e;
    if (hold && !rst_prev && !rst) begin
      checks++;
      if (!kx.rk_valid || kx.rk !== hold_rk || kx.rk_idx !== hold_idx) begin
        errors++;
        $display("FAIL hold_stable cyc %0d: valid=%0b idx=%0d rk=%h, required valid=1 idx=%0d rk=%h",
                 cyc, kx.rk_valid, kx.rk_idx, kx.rk, hold_idx, hold_rk);
      end
    end
    if (kx.rk_valid && kx.rk_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rk cyc %0d: got idx=%0d rk=%h, required no output",
                 cyc, kx.rk_idx, kx.rk);
      end else begin
        e = sb_q.pop_front();
        if (kx.rk_idx !== e.idx || kx.rk !== e.rk) begin
          errors++;
          $display("FAIL rk_stream cyc %0d: got idx=%0d rk=%h, required idx=%0d rk=%h",
                   cyc, kx.rk_idx, kx.rk, e.idx, e.rk);
        end
      end
      got[kx.rk_idx]     = kx.rk;
      got_cyc[kx.rk_idx] = cyc;
    end
    if (kx.done) begin
      done_cnt++;
      done_cyc = cyc;
      checks++;
      if (kx.busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_at_done cyc %0d: got %0b, required 0", cyc, kx.busy);
      end
    end
    hold     = kx.rk_valid && !kx.rk_ready;
    hold_rk  = kx.rk;
    hold_idx = kx.rk_idx;
    rst_prev = rst;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [255:0] k);
    kx.key   = k;
    kx.start = 1'b1;
    tick();
    kx.start = 1'b0;
    kx.key   = ~k;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL done_timeout: got %0d done pulses, required %0d", done_cnt, target);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   c0, base;

    vecs[0] = '{key: KEY_A3,  pct: 100, rk0: KEY_A3[255:128], full: 1'b1};
    vecs[1] = '{key: '0,      pct: 100, rk0: '0,              full: 1'b0};
    vecs[2] = '{key: KEY_C3,  pct: 100, rk0: KEY_C3[255:128], full: 1'b0};
    vecs[3] = '{key: KEY_A3,  pct: 30,  rk0: KEY_A3[255:128], full: 1'b1};

    init_sbox();
    kx.start = 1'b0;
    kx.key   = '0;
    rst      = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_rk_valid", 128'(kx.rk_valid), 128'd0);
    chk("reset_busy",     128'(kx.busy),     128'd0);
    chk("reset_done",     128'(kx.done),     128'd0);
    chk("reset_rk_idx",   128'(kx.rk_idx),   128'd0);
    chk("reset_rk",       kx.rk,             128'd0);
    tick();

    foreach (vecs[v]) begin
      ready_pct = vecs[v].pct;
      tick();
      c0   = cyc;
      base = done_cnt;
      push_model(vecs[v].key);
      launch(vecs[v].key);
      wait_done(base + 1);
      chk("queue_drained", 128'(sb_q.size()), 128'd0);
      chk("rk0_value", got[0], vecs[v].rk0);
      if (vecs[v].pct == 100) begin
        chk("rk0_cycle",  128'(got_cyc[0] - c0), 128'd1);
        chk("rk2_cycle",  128'(got_cyc[2] - c0), 128'd7);
        chk("rk14_cycle", 128'(got_cyc[14] - c0), 128'd67);
        chk("done_cycle", 128'(done_cyc - c0), 128'd68);
      end
      if (vecs[v].full) begin
        chk("a3_rk2",  got[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
        chk("a3_rk3_w0", 128'(got[3][127:96]), 128'h00000000_00000000_00000000_a8b09c1a);
        chk("a3_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);
      end
      repeat (3) tick();
    end
    ready_pct = 100;

    // Restart attempt mid-expansion with another key.
    tick();
    c0   = cyc;
    base = done_cnt;
    push_model(KEY_A3);
    launch(KEY_A3);
    while (cyc < c0 + 20) tick();
    kx.key   = KEY_C3;
    kx.start = 1'b1;
    tick();
    kx.start = 1'b0;
    wait_done(base + 1);
    chk("restart_done_cycle", 128'(done_cyc - c0), 128'd68);
    chk("restart_queue", 128'(sb_q.size()), 128'd0);
    chk("restart_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);
    repeat (3) tick();

    // Reset mid-expansion, then a fresh run.
    c0 = cyc;
    push_model(KEY_A3);
    launch(KEY_A3);
    while (cyc < c0 + 30) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete();
    chk("abort_rk_valid", 128'(kx.rk_valid), 128'd0);
    chk("abort_busy",     128'(kx.busy),     128'd0);
    repeat (6) tick();
    chk("abort_quiet_valid", 128'(kx.rk_valid), 128'd0);
    base = done_cnt;
    c0   = cyc;
    push_model(KEY_C3);
    launch(KEY_C3);
    wait_done(base + 1);
    chk("after_abort_done_cycle", 128'(done_cyc - c0), 128'd68);
    chk("after_abort_queue", 128'(sb_q.size()), 128'd0);
    repeat (3) tick();

    // Start held high: runs back to back with a one-cycle IDLE gap.
    c0   = cyc;
    base = done_cnt;
    push_model(KEY_A3);
    push_model(KEY_A3);
    kx.key   = KEY_A3;
    kx.start = 1'b1;
    wait_done(base + 1);
    chk("b2b_done1_cycle", 128'(done_cyc - c0), 128'd68);
    while (cyc < c0 + 100) tick();
    kx.start = 1'b0;
    wait_done(base + 2);
    chk("b2b_rk0_second_cycle", 128'(got_cyc[0] - c0), 128'd70);
    chk("b2b_done2_cycle", 128'(done_cyc - c0), 128'd137);
    chk("b2b_queue", 128'(sb_q.size()), 128'd0);
    repeat (6) tick();
    chk("b2b_no_third_run", 128'(done_cnt - base), 128'd2);
    chk("b2b_idle_busy", 128'(kx.busy), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
